dma_io_responder: RTL and testbench

//  Peripheral (IO-device) end of the DREQ/DACK DMA handshake. Raises DREQ on request and holds it

---
 rtl/dma_io_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_dma_io_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_io_responder.sv
// -----------------------------------------------------------------------------
// dma_io_responder
//
// Purpose:
//   Peripheral-side end of a DREQ/DACK DMA handshake. The device raises DREQ
//   while it wants a job done and keeps it up until the DMA controller signals
//   EOP. While the DMA owns the device, it issues read strobes (IOR_command)
//   and write strobes (IOW_command) against an internal word buffer that is
//   addressed by addressBus_IO:
//     - IOR_command : buffer[addressBus_IO] is driven onto dataBus with no
//                     clock latency. At all other times dataBus is tri-stated.
//     - IOW_command : dataBus is written into buffer[addressBus_IO] on the
//                     rising clock edge.
//
// Parameters:
//   DATA_W  data word width (default 32)
//   ADDR_W  addressBus_IO width (default 10)
//   DEPTH   number of buffer words; legal addresses are 0..DEPTH-1
//
// Ports:
//   CLK                   in     clock, rising edge
//   RST                   in     asynchronous active-high reset
//   Start_Requisting_DMA  in     device wants a transfer (level)
//   DACK                  in     DMA acknowledge, device selected
//   IOR_command           in     DMA read strobe  (device -> dataBus)
//   IOW_command           in     DMA write strobe (dataBus -> device)
//   EOP                   in     end of process from the DMA
//   addressBus_IO         in     buffer word address
//   dataBus               inout  shared data bus, driven only on a valid read
//   DREQ                  out    DMA request (registered)
//   done                  out    one-cycle pulse when a job ends on EOP
//   err                   out    sticky protocol/address error flag
//   xfer_count            out    (only with XFER_COUNT_EN) valid cycles in job
//
// Build option:
//   XFER_COUNT_EN - when defined, adds the xfer_count output: number of valid
//                   read/write cycles since the last IDLE->REQ transition,
//                   saturating at all-ones.
// -----------------------------------------------------------------------------
module dma_io_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start_Requisting_DMA,
  input  logic              DACK,
  input  logic              IOR_command,
  input  logic              IOW_command,
  input  logic              EOP,
  input  logic [ADDR_W-1:0] addressBus_IO,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic              DREQ,
  output logic              done,
  output logic              err
`ifdef XFER_COUNT_EN
  ,
  output logic [ADDR_W:0]   xfer_count
`endif
);

  // DEPTH widened by one bit so the range compare also works when DEPTH is
  // exactly 2**ADDR_W.
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  logic   r_dreq;
  logic   r_done;
  logic   r_err;

  // Word buffer. Not reset: contents survive RST by design.
  logic [DATA_W-1:0] r_buf [DEPTH];

  // ---------------------------------------------------------------------------
  // Cycle qualification
  // ---------------------------------------------------------------------------
  logic w_selected;     // DMA currently owns the device
  logic w_addr_ok;      // address inside the buffer
  logic w_any_strobe;
  logic w_both_strobes;
  logic w_rd_valid;
  logic w_wr_valid;
  logic w_err_set;

  // Strobes only mean something while in XFER with DACK; in any other state
  // they are silently ignored and never flag an error.
  assign w_selected     = (r_state == S_XFER) && DACK;
  assign w_addr_ok      = ({1'b0, addressBus_IO} < L_DEPTH);
  assign w_any_strobe   = IOR_command | IOW_command;
  assign w_both_strobes = IOR_command & IOW_command;

  assign w_rd_valid = w_selected &  IOR_command & ~IOW_command & w_addr_ok;
  assign w_wr_valid = w_selected & ~IOR_command &  IOW_command & w_addr_ok;

  // Conflicting strobes, or a single strobe to a missing word.
  assign w_err_set  = w_selected & (w_both_strobes | (w_any_strobe & ~w_addr_ok));

  // ---------------------------------------------------------------------------
  // Data bus: combinational read path. Because w_rd_valid depends on r_state,
  // which is cleared asynchronously, the bus is released the moment RST rises.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rd_data;

  assign w_rd_data = r_buf[addressBus_IO];
  assign dataBus   = w_rd_valid ? w_rd_data : {DATA_W{1'bz}};

  // ---------------------------------------------------------------------------
  // Buffer write port. No reset on purpose; during reset the state is IDLE so
  // w_wr_valid is low and nothing is written.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_wr_valid) begin
      r_buf[addressBus_IO] <= dataBus;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered DREQ/done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_dreq  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dreq <= 1'b0;
          if (Start_Requisting_DMA) begin
            r_state <= S_REQ;
            r_dreq  <= 1'b1;
          end
        end

        S_REQ: begin
          // An acknowledge wins over a withdrawn request: the DMA has
          // already committed to the cycle.
          if (DACK) begin
            r_state <= S_XFER;
            r_dreq  <= 1'b1;
          end else if (!Start_Requisting_DMA) begin
            r_state <= S_IDLE;
            r_dreq  <= 1'b0;
          end else begin
            r_dreq  <= 1'b1;
          end
        end

        S_XFER: begin
          // EOP beats everything; a dropped DACK is a pause (back to REQ
          // with DREQ still high) and takes precedence over an abort.
          if (EOP) begin
            r_state <= S_DONE;
            r_dreq  <= 1'b0;
            r_done  <= 1'b1;
          end else if (!DACK) begin
            r_state <= S_REQ;
            r_dreq  <= 1'b1;
          end else if (!Start_Requisting_DMA) begin
            r_state <= S_IDLE;
            r_dreq  <= 1'b0;
          end else begin
            r_dreq  <= 1'b1;
          end
        end

        S_DONE: begin
          // Always return to IDLE; a new job needs Start sampled there.
          r_state <= S_IDLE;
          r_dreq  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_dreq  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flag, cleared only by RST.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign DREQ = r_dreq;
  assign done = r_done;
  assign err  = r_err;

`ifdef XFER_COUNT_EN
  // ---------------------------------------------------------------------------
  // Per-job valid-cycle counter. Cleared when a new job is requested, so the
  // final count of the previous job stays visible through DONE and IDLE.
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0] r_xfer_count;
  logic            w_job_start;
  logic            w_cnt_full;

  assign w_job_start = (r_state == S_IDLE) && Start_Requisting_DMA;
  assign w_cnt_full  = &r_xfer_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_xfer_count <= '0;
    end else if (w_job_start) begin
      r_xfer_count <= '0;
    end else if ((w_rd_valid || w_wr_valid) && !w_cnt_full) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_dma_io_responder.sv
// -----------------------------------------------------------------------------
// tb_dma_io_responder
//
// Stimulus tasks drive one clock cycle at a time and push the expected
// observable response of that cycle into a queue, computed by a small
// behavioural model of the peripheral (job phase, word array, sticky error).
// A separate monitor pops one entry per cycle on the falling edge and
// compares. Whenever the device must not drive dataBus, the bench drives its
// own value and expects to read it back unchanged, so any stray drive by the
// device shows up as a corrupted value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dma_io_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int CMAX   = (1 << (ADDR_W + 1)) - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b1;
  logic              dack = 1'b0;
  logic              ior = 1'b0;
  logic              iow = 1'b0;
  logic              eop = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  wire  [DATA_W-1:0] dataBus;
  logic [DATA_W-1:0] drv_val = '0;
  logic              drv_en = 1'b1;
  logic              DREQ;
  logic              done;
  logic              err;
`ifdef XFER_COUNT_EN
  logic [ADDR_W:0]   xfer_count;
`endif

  assign dataBus = drv_en ? drv_val : {DATA_W{1'bz}};

  always #5 CLK = ~CLK;

  dma_io_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .Start_Requisting_DMA (start),
    .DACK                 (dack),
    .IOR_command          (ior),
    .IOW_command          (iow),
    .EOP                  (eop),
    .addressBus_IO        (addr),
    .dataBus              (dataBus),
    .DREQ                 (DREQ),
    .done                 (done),
    .err                  (err)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count           (xfer_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic              dreq;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] bus;
    logic [ADDR_W:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("DREQ",    {31'd0, DREQ}, {31'd0, e.dreq});
      chk("done",    {31'd0, done}, {31'd0, e.done});
      chk("err",     {31'd0, err},  {31'd0, e.err});
      chk("dataBus", dataBus,       e.bus);
`ifdef XFER_COUNT_EN
      chk("xfer_count", {{(DATA_W-ADDR_W-1){1'b0}}, xfer_count},
                        {{(DATA_W-ADDR_W-1){1'b0}}, e.cnt});
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: where the job is, what each word holds, error seen.
  // ---------------------------------------------------------------------------
  typedef enum int {PH_IDLE, PH_REQ, PH_XFER, PH_DONE} ph_t;

  ph_t               ph;
  logic              merr;
  int                mcnt;
  logic [DATA_W-1:0] mbuf [DEPTH];

  function automatic void model_reset();
    ph   = PH_IDLE;
    merr = 1'b0;
    mcnt = 0;
  endfunction

  function automatic bit owned_ok(bit dk, bit rd, bit wr, int a);
    return (ph == PH_XFER) && dk && (rd != wr) && (a < DEPTH);
  endfunction

  function automatic void model_edge(bit st, bit dk, bit rd, bit wr, bit ep,
                                     int a, logic [DATA_W-1:0] wd);
    bit ok;
    ok = owned_ok(dk, rd, wr, a);
    if (ok && wr) mbuf[a] = wd;
    if (ok && mcnt < CMAX) mcnt++;
    if ((ph == PH_XFER) && dk && ((rd && wr) || ((rd || wr) && a >= DEPTH)))
      merr = 1'b1;
    case (ph)
      PH_IDLE: if (st) begin ph = PH_REQ; mcnt = 0; end
      PH_REQ:  if (dk) ph = PH_XFER; else if (!st) ph = PH_IDLE;
      PH_XFER: if (ep) ph = PH_DONE; else if (!dk) ph = PH_REQ;
               else if (!st) ph = PH_IDLE;
      default: ph = PH_IDLE;
    endcase
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input bit rst, input bit st, input bit dk, input bit rd,
                      input bit wr, input bit ep, input int a,
                      input logic [DATA_W-1:0] wd);
    exp_t e;
    RST   = rst;
    start = st;
    dack  = dk;
    ior   = rd;
    iow   = wr;
    eop   = ep;
    addr  = a[ADDR_W-1:0];
    if (rst) model_reset();
    e.dreq = (ph == PH_REQ) || (ph == PH_XFER);
    e.done = (ph == PH_DONE);
    e.err  = merr;
    e.cnt  = (ADDR_W + 1)'(mcnt);
    if (owned_ok(dk, rd, wr, a) && rd) begin
      drv_en = 1'b0;
      e.bus  = mbuf[a];
    end else begin
      drv_en  = 1'b1;
      drv_val = wd;
      e.bus   = wd;
    end
    exp_q.push_back(e);
    @(posedge CLK);
    if (!rst) model_edge(st, dk, rd, wr, ep, a, wd);
    #1;
  endtask

  // Full job: request, acknowledge, one strobe per address, EOP on the last.
  task automatic job(input bit is_wr, input int lo, input int hi, input int base);
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 0, 0, 0, 0, $urandom);
    for (int a = lo; a <= hi; a++)
      step(0, 1, 1, !is_wr, is_wr, a == hi, a,
           is_wr ? DATA_W'(base + a) : DATA_W'($urandom));
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    $display("job %s addr %0d..%0d done (checks %0d)", is_wr ? "write" : "read",
             lo, hi, n_checks);
  endtask

  initial begin
    bit st, dk, rd, wr, ep;
    int a;
    model_reset();
    @(posedge CLK);
    #1;

    // Reset held with Start high, then released: DREQ one cycle later.
    step(1, 1, 0, 0, 0, 0, 0, $urandom);
    step(1, 1, 1, 1, 0, 0, 5, $urandom);
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    $display("reset sequence done");

    // Preload, then the 90..129 write job inside a known-valued frame.
    job(1, 10, 59, 100);
    job(1, 89, 130, 7000);
    job(1, 90, 129, 500);
    job(0, 10, 59, 0);
    job(0, 89, 130, 0);

    // Pause then abort: no done pulse, bus released while DACK is low.
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 1, 0, 0, 12, $urandom);
    step(0, 1, 0, 1, 0, 0, 13, $urandom);
    step(0, 1, 0, 1, 0, 0, 13, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    $display("pause/abort done");

    // Both strobes: no drive, no write, sticky err.
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 1, 1, 0, 20, 32'hDEAD_0014);
    step(0, 1, 1, 1, 0, 0, 20, $urandom);
    step(0, 1, 1, 1, 0, 1, 21, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    $display("protocol error done");

    // Reset in the middle of an active read; written words survive.
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 0, 1, 0, 30, 32'h3030_3030);
    step(1, 1, 1, 1, 0, 0, 30, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    job(0, 29, 31, 0);
    $display("mid-transfer reset done");

    // Randomized traffic over the preloaded range.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 7) != 0);
      dk = ($urandom_range(0, 3) != 0);
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 4) == 0);
      ep = ($urandom_range(0, 15) == 0);
      a  = $urandom_range(10, 59);
      // Keep withdrawn requests away from the DACK/Start tie cases.
      if (!st && ph == PH_REQ)  dk = 0;
      if (!st && ph == PH_XFER) dk = 1;
      step(0, st, dk, rd, wr, ep, a, $urandom);
    end
    $display("random traffic done");

    step(1, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
